uart_cmd_ctrl: RTL
==================

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 24'd5000000, inter-byte timeout in clk cycles.
REQ-002 SHALL have parameter ERR_BYTE, default 8'h45, the error response byte 'E'.
REQ-003 SHALL have parameter ACK_BYTE, default 8'h4B, the write acknowledge byte 'K'.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-006 SHALL have port data_out, input, 8, the received byte from the UART.
REQ-007 SHALL have port rxrdy, input, 1, UART received byte available.
REQ-008 SHALL have port parity_err, input, 1, UART parity error on the current byte.
REQ-009 SHALL have port framing_err, input, 1, UART framing error on the current byte.
REQ-010 SHALL have port overflow, input, 1, UART receive overflow.
REQ-011 SHALL have port oen, output, 1, active-low UART read strobe.
REQ-012 SHALL have port txrdy, input, 1, UART transmitter can accept a byte.
REQ-013 SHALL have port data_in, output, 8, the byte to transmit.
REQ-014 SHALL have port wen, output, 1, active-low UART write strobe.
REQ-015 SHALL have port led, output, 4, equal to reg0[3:0].
REQ-016 SHALL have port err_cnt, output, 8, saturating error counter.
REQ-017 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-018 SHALL hold registers reg0..reg2, each 8 bits and read/write; address 3 SHALL read err_cnt and is read-only.
REQ-019 SHALL accept command frames of opcode 8'h57 'W' + addr + data, and 8'h52 'R' + addr.
REQ-020 SHALL implement states IDLE, RX_WAIT, RX_REL, EXEC, TX_WAIT, TX_REL.
REQ-021 RX_WAIT: when rxrdy=1, SHALL drive oen=0 for exactly 1 cycle, capture data_out and the error flags in that cycle, then go to RX_REL.
REQ-022 RX_REL: SHALL hold oen=1 until rxrdy=0, then SHALL advance the byte index, or go to EXEC once the frame is complete.
REQ-023 IDLE: when rxrdy=1, SHALL enter RX_WAIT for the opcode with no extra cycle lost.
REQ-024 The opcode decision SHALL be made at capture: W expects 2 more bytes, R expects 1, any other opcode SHALL go directly to EXEC with the error condition.
REQ-025 A captured byte with parity_err or framing_err set SHALL mark the frame bad; the remaining bytes SHALL still be collected, then EXEC.
REQ-026 EXEC: an address above 3, a write to address 3, or a bad frame SHALL select response ERR_BYTE and increment err_cnt.
REQ-027 EXEC valid W SHALL update reg[addr] and select response ACK_BYTE.
REQ-028 EXEC valid R SHALL select response reg[addr], or err_cnt for address 3.
REQ-029 EXEC SHALL take 1 cycle, then go to TX_WAIT.
REQ-030 TX_WAIT: when txrdy=1, SHALL drive data_in=response and wen=0 for exactly 1 cycle, then go to TX_REL.
REQ-031 TX_REL: SHALL wait for txrdy=0, then go to IDLE.
REQ-032 data_in SHALL hold its value until the next response.
REQ-033 The timeout counter SHALL clear on every capture and count in RX_WAIT/RX_REL after the opcode.
REQ-034 When the timeout counter reaches TIMEOUT, the block SHALL go to IDLE with no response and increment err_cnt.
REQ-035 A rising edge of overflow SHALL increment err_cnt once.
REQ-036 err_cnt SHALL saturate at 8'hFF.
REQ-037 When two increments occur in the same cycle, err_cnt SHALL add 2, still saturating.
REQ-038 oen and wen SHALL never be low in the same cycle.
REQ-039 Each strobe SHALL only ever be low for a single-cycle pulse.

Reset
REQ-040 On rst=1, outputs SHALL go immediately to oen=1, wen=1, data_in=8'h00, led=4'h0, err_cnt=8'h00, busy=0, with state IDLE, reg0..reg2=8'h00 and the timeout counter at 0.
REQ-041 An rst assertion mid-frame or mid-transmit SHALL abort with no further strobes.
REQ-042 After rst deasserts, the first rising edge SHALL begin operation from IDLE.

Verification
REQ-043 Write: bytes 57,00,0A -> response 4B, led=4'hA; then bytes 52,00 -> response 0A.
REQ-044 Invalid write: bytes 57,03,11 -> response 45, err_cnt=1; bytes 52,03 -> response 01.
REQ-045 Bad opcode and bad byte: byte 33 -> response 45; bytes 57,01 with the data byte carrying parity_err=1 -> response 45, reg1 unchanged.
REQ-046 Timeout: bytes 57,01 then idle for TIMEOUT cycles -> state IDLE, no wen pulse, err_cnt incremented; the next frame completes normally.
REQ-047 Handshake: txrdy held low for 100 cycles in TX_WAIT -> wen stays high, then a single-cycle pulse after txrdy rises; rxrdy held high -> exactly one oen pulse per byte.
REQ-048 Reset and saturation: rst pulsed during TX_WAIT -> outputs at reset values, no wen pulse; 300 overflow edges -> err_cnt=FF.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: byte-oriented command controller sitting behind a UART.
// Accepts 'W' addr data and 'R' addr frames. It updates or reads three
// 8-bit registers, or the error counter at address 3, and returns one
// response byte for each frame.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   data_out, rxrdy      received byte and byte-available flag from the UART
//   parity_err,          per-byte receive error flags
//   framing_err
//   overflow             UART receive overflow (counted on its rising edge)
//   oen                  active-low read strobe to the UART
//   txrdy                UART transmitter ready
//   data_in, wen         response byte and active-low write strobe
//   led                  reg0[3:0]
//   err_cnt              saturating error counter
//   busy                 high whenever the FSM is not idle
module uart_cmd_ctrl #(
    parameter logic [23:0] TIMEOUT  = 24'd5000000,
    parameter logic [7:0]  ERR_BYTE = 8'h45,
    parameter logic [7:0]  ACK_BYTE = 8'h4B
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_out,
    input  logic       rxrdy,
    input  logic       parity_err,
    input  logic       framing_err,
    input  logic       overflow,
    output logic       oen,
    input  logic       txrdy,
    output logic [7:0] data_in,
    output logic       wen,
    output logic [3:0] led,
    output logic [7:0] err_cnt,
    output logic       busy
);

    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_R = 8'h52;

    typedef enum logic [2:0] {IDLE, RX_WAIT, RX_REL, EXEC, TX_WAIT, TX_REL} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  last_q, last_d;
    logic [7:0]  opc_q, opc_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic        bad_q, bad_d;
    logic [23:0] tmo_q, tmo_d;
    logic [7:0]  resp_q, resp_d;
    logic [7:0]  reg0_q, reg0_d, reg1_q, reg1_d, reg2_q, reg2_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        ovf_q;
    logic        oen_q, oen_d, wen_q, wen_d;
    logic [7:0]  data_in_q, data_in_d;
    logic        busy_q, busy_d;

    logic        fsm_err;
    logic        ovf_rise;
    logic        count_en;
    logic [1:0]  err_inc;
    logic [8:0]  err_sum;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            last_q    <= 2'd0;
            opc_q     <= 8'h00;
            addr_q    <= 8'h00;
            wdat_q    <= 8'h00;
            bad_q     <= 1'b0;
            tmo_q     <= 24'd0;
            resp_q    <= 8'h00;
            reg0_q    <= 8'h00;
            reg1_q    <= 8'h00;
            reg2_q    <= 8'h00;
            err_cnt_q <= 8'h00;
            ovf_q     <= 1'b0;
            oen_q     <= 1'b1;
            wen_q     <= 1'b1;
            data_in_q <= 8'h00;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            opc_q     <= opc_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            bad_q     <= bad_d;
            tmo_q     <= tmo_d;
            resp_q    <= resp_d;
            reg0_q    <= reg0_d;
            reg1_q    <= reg1_d;
            reg2_q    <= reg2_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= overflow;
            oen_q     <= oen_d;
            wen_q     <= wen_d;
            data_in_q <= data_in_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, frame decode, execution and error counting
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        opc_d     = opc_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        bad_d     = bad_q;
        tmo_d     = tmo_q;
        resp_d    = resp_q;
        reg0_d    = reg0_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        oen_d     = 1'b1;
        wen_d     = 1'b1;
        data_in_d = data_in_q;
        fsm_err   = 1'b0;

        // Timeout only runs once the opcode has been captured
        count_en = (state_q == RX_REL) || ((state_q == RX_WAIT) && (idx_q != 2'd0));
        if (count_en) begin
            tmo_d = tmo_q + 24'd1;
        end

        case (state_q)
            IDLE: begin
                idx_d = 2'd0;
                bad_d = 1'b0;
                tmo_d = 24'd0;
                if (rxrdy) begin
                    state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (rxrdy) begin
                    oen_d   = 1'b0;
                    tmo_d   = 24'd0;
                    state_d = RX_REL;
                    if (parity_err || framing_err) begin
                        bad_d = 1'b1;
                    end
                    case (idx_q)
                        2'd0: begin
                            opc_d = data_out;
                            if (data_out == OP_W) begin
                                last_d = 2'd2;
                            end else if (data_out == OP_R) begin
                                last_d = 2'd1;
                            end else begin
                                // Unknown opcode: skip the rest and report the error
                                last_d  = 2'd0;
                                bad_d   = 1'b1;
                                state_d = EXEC;
                            end
                        end
                        2'd1:    addr_d = data_out;
                        default: wdat_d = data_out;
                    endcase
                end else if (count_en && (tmo_q >= TIMEOUT)) begin
                    tmo_d   = 24'd0;
                    fsm_err = 1'b1;
                    state_d = IDLE;
                end
            end
            RX_REL: begin
                if (!rxrdy) begin
                    if (idx_q == last_q) begin
                        state_d = EXEC;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        state_d = RX_WAIT;
                    end
                end else if (tmo_q >= TIMEOUT) begin
                    tmo_d   = 24'd0;
                    fsm_err = 1'b1;
                    state_d = IDLE;
                end
            end
            EXEC: begin
                state_d = TX_WAIT;
                if (bad_q || (addr_q > 8'd3) || ((opc_q == OP_W) && (addr_q == 8'd3))) begin
                    resp_d  = ERR_BYTE;
                    fsm_err = 1'b1;
                end else if (opc_q == OP_W) begin
                    resp_d = ACK_BYTE;
                    case (addr_q[1:0])
                        2'd0:    reg0_d = wdat_q;
                        2'd1:    reg1_d = wdat_q;
                        default: reg2_d = wdat_q;
                    endcase
                end else begin
                    case (addr_q[1:0])
                        2'd0:    resp_d = reg0_q;
                        2'd1:    resp_d = reg1_q;
                        2'd2:    resp_d = reg2_q;
                        default: resp_d = err_cnt_q;
                    endcase
                end
            end
            TX_WAIT: begin
                if (txrdy) begin
                    wen_d     = 1'b0;
                    data_in_d = resp_q;
                    state_d   = TX_REL;
                end
            end
            TX_REL: begin
                if (!txrdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Frame errors and overflow edges can coincide; add both, saturating
        ovf_rise  = overflow && !ovf_q;
        err_inc   = 2'({1'b0, fsm_err}) + 2'({1'b0, ovf_rise});
        err_sum   = 9'({1'b0, err_cnt_q}) + 9'(err_inc);
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];

        busy_d = (state_d != IDLE);
    end

    assign oen     = oen_q;
    assign wen     = wen_q;
    assign data_in = data_in_q;
    assign led     = reg0_q[3:0];
    assign err_cnt = err_cnt_q;
    assign busy    = busy_q;

endmodule
